// File: rtl/bmp180_cmd_seq_pkg.sv
// Shared BMP180 definitions: opcodes, register map, conversion times, sequencer states
// and the combinational command decode table.
package bmp180_cmd_seq_pkg;

  localparam int unsigned TMR_W = 21;

  localparam logic [7:0] OP_END   = 8'h00;
  localparam logic [7:0] OP_CALIB = 8'hAA;
  localparam logic [7:0] OP_ID    = 8'hD0;
  localparam logic [7:0] OP_SRST  = 8'hB6;
  localparam logic [7:0] OP_TEMP  = 8'h2E;
  localparam logic [7:0] OP_PRES0 = 8'h34;
  localparam logic [7:0] OP_PRES1 = 8'h74;
  localparam logic [7:0] OP_PRES2 = 8'hB4;
  localparam logic [7:0] OP_PRES3 = 8'hF4;

  localparam logic [7:0] REG_CALIB = 8'hAA;
  localparam logic [7:0] REG_ID    = 8'hD0;
  localparam logic [7:0] REG_SRST  = 8'hE0;
  localparam logic [7:0] REG_CTRL  = 8'hF4;
  localparam logic [7:0] REG_OUT   = 8'hF6;

  localparam logic [15:0] T_TEMP_US  = 16'd4500;
  localparam logic [15:0] T_PRES0_US = 16'd4500;
  localparam logic [15:0] T_PRES1_US = 16'd7500;
  localparam logic [15:0] T_PRES2_US = 16'd13500;
  localparam logic [15:0] T_PRES3_US = 16'd25500;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_REQ    = 3'd3;
  localparam logic [2:0] ST_XFER   = 3'd4;
  localparam logic [2:0] ST_WAIT   = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;
  localparam logic [2:0] ST_ERR    = 3'd7;

  typedef struct packed {
    logic        valid;
    logic        term;
    logic        rw;
    logic [7:0]  reg_a;
    logic [7:0]  wdata;
    logic [4:0]  nbytes;
    logic        has_wait;
    logic [15:0] wait_us;
    logic        has_rd;
    logic [4:0]  rd_n;
  } dec_t;

  // First transaction of a command, plus an optional wait and an optional read of REG_OUT.
  function automatic dec_t decode_op(input logic [7:0] op, input logic [15:0] t_rst_us);
    dec_t d;
    d       = '0;
    d.valid = 1'b1;
    case (op)
      OP_END:   d.term = 1'b1;
      OP_CALIB: begin
        d.rw     = 1'b1;
        d.reg_a  = REG_CALIB;
        d.nbytes = 5'd22;
      end
      OP_ID: begin
        d.rw     = 1'b1;
        d.reg_a  = REG_ID;
        d.nbytes = 5'd1;
      end
      OP_SRST: begin
        d.reg_a    = REG_SRST;
        d.wdata    = op;
        d.nbytes   = 5'd1;
        d.has_wait = 1'b1;
        d.wait_us  = t_rst_us;
      end
      OP_TEMP: begin
        d.reg_a    = REG_CTRL;
        d.wdata    = op;
        d.nbytes   = 5'd1;
        d.has_wait = 1'b1;
        d.wait_us  = T_TEMP_US;
        d.has_rd   = 1'b1;
        d.rd_n     = 5'd2;
      end
      OP_PRES0, OP_PRES1, OP_PRES2, OP_PRES3: begin
        d.reg_a    = REG_CTRL;
        d.wdata    = op;
        d.nbytes   = 5'd1;
        d.has_wait = 1'b1;
        d.has_rd   = 1'b1;
        d.rd_n     = 5'd3;
        case (op)
          OP_PRES0: d.wait_us = T_PRES0_US;
          OP_PRES1: d.wait_us = T_PRES1_US;
          OP_PRES2: d.wait_us = T_PRES2_US;
          default:  d.wait_us = T_PRES3_US;
        endcase
      end
      default:  d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/bmp180_cmd_seq_conv_timer.sv
// Conversion wait timer: loads a cycle count on I_START, counts down to zero and
// pulses O_EXPIRE for one cycle when it gets there.
module conv_timer #(
  parameter int unsigned W = 21
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         I_START,
  input  logic [W-1:0] I_LOAD,
  output logic         O_EXPIRE
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         run_q, run_d;

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (I_START) begin
      cnt_d = I_LOAD;
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) run_d = 1'b0;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign O_EXPIRE = run_q && (cnt_q == '0);

endmodule

// File: rtl/bmp180_cmd_seq.sv
// BMP180 command sequencer: walks the command ROM from address 0, expands each opcode
// into I2C register transactions with conversion waits, and stops on the 0x00 terminator.
module bmp180_cmd_seq
  import bmp180_cmd_seq_pkg::*;
#(
  parameter int unsigned ADDR_ROM_SZ = 4,
  parameter int unsigned DATA_ROM_SZ = 8,
  parameter int unsigned CYC_PER_US  = 50,
  parameter int unsigned T_RST_US    = 10000
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   I_START,
  output logic [ADDR_ROM_SZ-1:0] O_ADDR_ROM,
  input  logic [ADDR_ROM_SZ-1:0] I_ADDR_ROM,
  input  logic [DATA_ROM_SZ-1:0] I_DATA_ROM,
  output logic                   O_I2C_START,
  output logic                   O_I2C_RW,
  output logic [7:0]             O_I2C_REG,
  output logic [7:0]             O_I2C_WDATA,
  output logic [4:0]             O_I2C_NBYTES,
  input  logic                   I_I2C_BUSY,
  input  logic                   I_I2C_DONE,
  input  logic                   I_I2C_NACK,
  output logic [7:0]             O_CMD,
  output logic                   O_BUSY,
  output logic                   O_DONE,
  output logic                   O_ERR
);

  logic [2:0]             state_q, state_d;
  logic [ADDR_ROM_SZ-1:0] pc_q, pc_d;
  logic [7:0]             cmd_q, cmd_d;
  logic                   err_q, err_d;
  logic                   rw_q, rw_d;
  logic [7:0]             reg_q, reg_d;
  logic [7:0]             wdata_q, wdata_d;
  logic [4:0]             nbytes_q, nbytes_d;
  logic                   has_wait_q, has_wait_d;
  logic [15:0]            wait_us_q, wait_us_d;
  logic                   has_rd_q, has_rd_d;
  logic [4:0]             rd_n_q, rd_n_d;
  logic                   second_q, second_d;

  logic [7:0]       rom_word;
  dec_t             dec;
  logic             tmr_start, tmr_expire;
  logic [TMR_W-1:0] tmr_load;
  logic             cmd_fin, fault;

  assign rom_word = 8'(I_DATA_ROM);
  assign tmr_load = TMR_W'(32'(wait_us_q) * 32'(CYC_PER_US) - 32'd1);

  conv_timer #(.W(TMR_W)) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .I_START  (tmr_start),
    .I_LOAD   (tmr_load),
    .O_EXPIRE (tmr_expire)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cmd_d      = cmd_q;
    err_d      = err_q;
    rw_d       = rw_q;
    reg_d      = reg_q;
    wdata_d    = wdata_q;
    nbytes_d   = nbytes_q;
    has_wait_d = has_wait_q;
    wait_us_d  = wait_us_q;
    has_rd_d   = has_rd_q;
    rd_n_d     = rd_n_q;
    second_d   = second_q;
    tmr_start  = 1'b0;
    cmd_fin    = 1'b0;
    fault      = 1'b0;
    dec        = decode_op(rom_word, 16'(T_RST_US));

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        state_d = ST_IDLE;
        if (I_START) begin
          state_d = ST_FETCH;
          pc_d    = '0;
          err_d   = 1'b0;
        end
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        // A stale ROM echo means the address has not settled yet; fetch again.
        if (I_ADDR_ROM != pc_q) begin
          state_d = ST_FETCH;
        end else begin
          cmd_d = rom_word;
          if (dec.term) begin
            state_d = ST_DONE;
          end else if (!dec.valid) begin
            fault = 1'b1;
          end else begin
            rw_d       = dec.rw;
            reg_d      = dec.reg_a;
            wdata_d    = dec.wdata;
            nbytes_d   = dec.nbytes;
            has_wait_d = dec.has_wait;
            wait_us_d  = dec.wait_us;
            has_rd_d   = dec.has_rd;
            rd_n_d     = dec.rd_n;
            second_d   = 1'b0;
            state_d    = ST_REQ;
          end
        end
      end
      ST_REQ: if (!I_I2C_BUSY) state_d = ST_XFER;
      ST_XFER: begin
        if (I_I2C_DONE) begin
          if (I_I2C_NACK) begin
            fault = 1'b1;
          end else if (!second_q && has_wait_q) begin
            tmr_start = 1'b1;
            state_d   = ST_WAIT;
          end else begin
            cmd_fin = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (tmr_expire) begin
          if (has_rd_q) begin
            second_d = 1'b1;
            rw_d     = 1'b1;
            reg_d    = REG_OUT;
            nbytes_d = rd_n_q;
            state_d  = ST_REQ;
          end else begin
            cmd_fin = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Finishing the last ROM word without a terminator would wrap the PC: treat as error.
    if (cmd_fin) begin
      if (pc_q == '1) begin
        fault = 1'b1;
      end else begin
        pc_d    = pc_q + 1'b1;
        state_d = ST_FETCH;
      end
    end
    if (fault) begin
      state_d = ST_ERR;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      cmd_q      <= '0;
      err_q      <= 1'b0;
      rw_q       <= 1'b0;
      reg_q      <= '0;
      wdata_q    <= '0;
      nbytes_q   <= '0;
      has_wait_q <= 1'b0;
      wait_us_q  <= '0;
      has_rd_q   <= 1'b0;
      rd_n_q     <= '0;
      second_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cmd_q      <= cmd_d;
      err_q      <= err_d;
      rw_q       <= rw_d;
      reg_q      <= reg_d;
      wdata_q    <= wdata_d;
      nbytes_q   <= nbytes_d;
      has_wait_q <= has_wait_d;
      wait_us_q  <= wait_us_d;
      has_rd_q   <= has_rd_d;
      rd_n_q     <= rd_n_d;
      second_q   <= second_d;
    end
  end

  assign O_ADDR_ROM   = pc_q;
  assign O_I2C_START  = (state_q == ST_REQ) && !I_I2C_BUSY;
  assign O_I2C_RW     = rw_q;
  assign O_I2C_REG    = reg_q;
  assign O_I2C_WDATA  = wdata_q;
  assign O_I2C_NBYTES = nbytes_q;
  assign O_CMD        = cmd_q;
  assign O_BUSY       = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERR);
  assign O_DONE       = (state_q == ST_DONE);
  assign O_ERR        = err_q;

endmodule

// File: tb/tb_bmp180_cmd_seq.sv
// Bench for bmp180_cmd_seq: ROM model, I2C master model with a transaction scoreboard,
// and scenario tasks for programs, timing gaps, errors and mid-run reset.
module tb_bmp180_cmd_seq;

  localparam int CYC  = 1;
  localparam int TRST = 1000;
  localparam int LAT  = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       I_START = 1'b0;
  logic [3:0] O_ADDR_ROM;
  logic [3:0] rom_addr = '0;
  logic [7:0] rom_data = '0;
  logic [7:0] rom_mem [16];
  logic       O_I2C_START, O_I2C_RW;
  logic [7:0] O_I2C_REG, O_I2C_WDATA, O_CMD;
  logic [4:0] O_I2C_NBYTES;
  logic       O_BUSY, O_DONE, O_ERR;
  logic       i2c_busy = 1'b0, i2c_done = 1'b0, i2c_nack = 1'b0;
  logic       inj_done = 1'b0, nack_next = 1'b0;
  logic [37:0] outs;

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;
  int i2c_cnt = 0;

  typedef struct {
    logic       rw;
    logic [7:0] rg;
    logic [7:0] wd;
    logic [4:0] nb;
    logic [7:0] cmd;
  } txn_t;

  txn_t exp_q[$];
  int   starts[$];
  int   dones[$];

  bmp180_cmd_seq #(
    .ADDR_ROM_SZ (4),
    .DATA_ROM_SZ (8),
    .CYC_PER_US  (CYC),
    .T_RST_US    (TRST)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .I_START      (I_START),
    .O_ADDR_ROM   (O_ADDR_ROM),
    .I_ADDR_ROM   (rom_addr),
    .I_DATA_ROM   (rom_data),
    .O_I2C_START  (O_I2C_START),
    .O_I2C_RW     (O_I2C_RW),
    .O_I2C_REG    (O_I2C_REG),
    .O_I2C_WDATA  (O_I2C_WDATA),
    .O_I2C_NBYTES (O_I2C_NBYTES),
    .I_I2C_BUSY   (i2c_busy),
    .I_I2C_DONE   (i2c_done | inj_done),
    .I_I2C_NACK   (i2c_nack),
    .O_CMD        (O_CMD),
    .O_BUSY       (O_BUSY),
    .O_DONE       (O_DONE),
    .O_ERR        (O_ERR)
  );

  assign outs = {O_ADDR_ROM, O_I2C_START, O_I2C_RW, O_I2C_REG, O_I2C_WDATA,
                 O_I2C_NBYTES, O_CMD, O_BUSY, O_DONE, O_ERR};

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK) begin
    rom_addr <= O_ADDR_ROM;
    rom_data <= rom_mem[O_ADDR_ROM];
  end

  // I2C master model: accepts a start, stays busy LAT cycles, then pulses done.
  always @(negedge CLK) begin : i2c_model
    txn_t e;
    i2c_done = 1'b0;
    i2c_nack = 1'b0;
    if (RST) begin
      i2c_cnt  = 0;
      i2c_busy = 1'b0;
    end else if (i2c_cnt > 0) begin
      i2c_busy = 1'b1;
      i2c_cnt  = i2c_cnt - 1;
      if (i2c_cnt == 0) begin
        i2c_busy = 1'b0;
        i2c_done = 1'b1;
        i2c_nack = nack_next;
        dones.push_back(cyc);
      end
    end else if (O_I2C_START) begin
      i2c_cnt = LAT;
      starts.push_back(cyc);
      n_assert++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL i2c_unexpected_start: got rw=%0d reg=%h cmd=%h, expected no transaction",
                 O_I2C_RW, O_I2C_REG, O_CMD);
      end else begin
        e = exp_q.pop_front();
        if ((O_I2C_RW !== e.rw) || (O_I2C_REG !== e.rg) || (O_CMD !== e.cmd) ||
            (!e.rw && (O_I2C_WDATA !== e.wd)) || (e.rw && (O_I2C_NBYTES !== e.nb))) begin
          n_fail++;
          $display("FAIL i2c_txn: got rw=%0d reg=%h wdata=%h nbytes=%0d cmd=%h, expected rw=%0d reg=%h wdata=%h nbytes=%0d cmd=%h",
                   O_I2C_RW, O_I2C_REG, O_I2C_WDATA, O_I2C_NBYTES, O_CMD,
                   e.rw, e.rg, e.wd, e.nb, e.cmd);
        end
      end
    end
  end

  task automatic clear_rom(input logic [7:0] fill);
    for (int i = 0; i < 16; i++) rom_mem[i] = fill;
    starts.delete();
    dones.delete();
  endtask

  task automatic push_txn(input logic rw, input logic [7:0] rg, input logic [7:0] wd,
                          input logic [4:0] nb, input logic [7:0] cmd);
    txn_t t;
    t.rw = rw; t.rg = rg; t.wd = wd; t.nb = nb; t.cmd = cmd;
    exp_q.push_back(t);
  endtask

  task automatic pulse_start;
    @(negedge CLK) I_START = 1'b1;
    @(negedge CLK) I_START = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit got_done, output bit got_err,
                          output int at_cyc);
    got_done = 1'b0;
    got_err  = 1'b0;
    at_cyc   = -1;
    for (int i = 0; i < budget; i++) begin
      if (O_DONE) begin got_done = 1'b1; at_cyc = cyc; break; end
      if (O_ERR)  begin got_err  = 1'b1; at_cyc = cyc; break; end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    n_assert++;
    if (outs !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h, expected 0", outs);
    end
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    n_assert++;
    if (outs !== '0) begin
      n_fail++; $display("FAIL idle_after_reset: got %h, expected 0", outs);
    end
  endtask

  task automatic test_single_read;
    bit gd, ge; int t;
    clear_rom(8'h00);
    rom_mem[0] = 8'hD0;
    push_txn(1'b1, 8'hD0, 8'h00, 5'd1, 8'hD0);
    pulse_start();
    wait_end(200, gd, ge, t);
    n_assert++;
    if (!gd || ge) begin
      n_fail++; $display("FAIL single_end: got done=%0d err=%0d, expected done=1 err=0", gd, ge);
    end
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL single_txn_count: got %0d missing, expected 0", exp_q.size());
    end
    n_assert++;
    if (O_ADDR_ROM !== 4'd1 || O_BUSY !== 1'b0) begin
      n_fail++; $display("FAIL single_pc_stop: got pc=%0d busy=%0d, expected pc=1 busy=0", O_ADDR_ROM, O_BUSY);
    end
    @(negedge CLK);
    n_assert++;
    if (O_DONE !== 1'b0) begin
      n_fail++; $display("FAIL done_pulse_width: got %0d, expected 0", O_DONE);
    end
  endtask

  task automatic test_sequence;
    bit gd, ge; int t; int g1, g2;
    clear_rom(8'h00);
    rom_mem[0] = 8'hAA; rom_mem[1] = 8'h2E; rom_mem[2] = 8'h34;
    push_txn(1'b1, 8'hAA, 8'h00, 5'd22, 8'hAA);
    push_txn(1'b0, 8'hF4, 8'h2E, 5'd1,  8'h2E);
    push_txn(1'b1, 8'hF6, 8'h00, 5'd2,  8'h2E);
    push_txn(1'b0, 8'hF4, 8'h34, 5'd1,  8'h34);
    push_txn(1'b1, 8'hF6, 8'h00, 5'd3,  8'h34);
    pulse_start();
    fork
      wait_end(20000, gd, ge, t);
      begin
        // stray transfer-complete while waiting on a conversion
        repeat (3000) @(negedge CLK);
        inj_done = 1'b1;
        @(negedge CLK) inj_done = 1'b0;
      end
    join
    n_assert++;
    if (!gd || ge || exp_q.size() != 0) begin
      n_fail++; $display("FAIL seq_end: got done=%0d err=%0d left=%0d, expected done=1 err=0 left=0",
                         gd, ge, exp_q.size());
    end
    g1 = (starts.size() > 2 && dones.size() > 1) ? starts[2] - dones[1] : -1;
    g2 = (starts.size() > 4 && dones.size() > 3) ? starts[4] - dones[3] : -1;
    n_assert++;
    if (g1 < 4500*CYC - 2 || g1 > 4500*CYC + 2) begin
      n_fail++; $display("FAIL temp_gap: got %0d cycles, expected %0d +/-2", g1, 4500*CYC);
    end
    n_assert++;
    if (g2 < 4500*CYC - 2 || g2 > 4500*CYC + 2) begin
      n_fail++; $display("FAIL pres0_gap: got %0d cycles, expected %0d +/-2", g2, 4500*CYC);
    end
  endtask

  task automatic test_long_conv;
    bit gd, ge; int t; int g;
    clear_rom(8'h00);
    rom_mem[0] = 8'hF4;
    push_txn(1'b0, 8'hF4, 8'hF4, 5'd1, 8'hF4);
    push_txn(1'b1, 8'hF6, 8'h00, 5'd3, 8'hF4);
    pulse_start();
    wait_end(30000, gd, ge, t);
    g = (starts.size() > 1 && dones.size() > 0) ? starts[1] - dones[0] : -1;
    n_assert++;
    if (!gd || g < 25500*CYC - 2 || g > 25500*CYC + 2) begin
      n_fail++; $display("FAIL pres3_gap: got done=%0d gap=%0d, expected done=1 gap=%0d +/-2",
                         gd, g, 25500*CYC);
    end
  endtask

  task automatic test_soft_reset;
    bit gd, ge; int t; int g;
    clear_rom(8'h00);
    rom_mem[0] = 8'hB6;
    push_txn(1'b0, 8'hE0, 8'hB6, 5'd1, 8'hB6);
    pulse_start();
    wait_end(TRST*CYC + 500, gd, ge, t);
    g = (dones.size() > 0) ? t - dones[0] : -1;
    n_assert++;
    if (!gd || g < TRST*CYC || g > TRST*CYC + 5) begin
      n_fail++; $display("FAIL srst_wait: got done=%0d wait=%0d, expected done=1 wait=%0d..%0d",
                         gd, g, TRST*CYC, TRST*CYC + 5);
    end
  endtask

  task automatic test_bad_opcode;
    bit gd, ge; int t;
    clear_rom(8'h00);
    rom_mem[0] = 8'h55;
    pulse_start();
    wait_end(100, gd, ge, t);
    n_assert++;
    if (!ge || gd || O_BUSY !== 1'b0 || O_CMD !== 8'h55 || starts.size() != 0) begin
      n_fail++; $display("FAIL bad_opcode: got err=%0d done=%0d busy=%0d cmd=%h starts=%0d, expected err=1 done=0 busy=0 cmd=55 starts=0",
                         ge, gd, O_BUSY, O_CMD, starts.size());
    end
  endtask

  task automatic test_nack;
    bit gd, ge; int t;
    clear_rom(8'h00);
    rom_mem[0] = 8'h2E;
    nack_next = 1'b1;
    push_txn(1'b0, 8'hF4, 8'h2E, 5'd1, 8'h2E);
    pulse_start();
    wait_end(200, gd, ge, t);
    nack_next = 1'b0;
    repeat (3) @(negedge CLK);
    n_assert++;
    if (!ge || O_ERR !== 1'b1 || O_BUSY !== 1'b0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL nack_err: got err=%0d O_ERR=%0d busy=%0d left=%0d, expected 1 1 0 0",
                         ge, O_ERR, O_BUSY, exp_q.size());
    end
    rom_mem[0] = 8'hD0;
    push_txn(1'b1, 8'hD0, 8'h00, 5'd1, 8'hD0);
    pulse_start();
    n_assert++;
    if (O_ERR !== 1'b0 || O_BUSY !== 1'b1) begin
      n_fail++; $display("FAIL err_clear_on_start: got err=%0d busy=%0d, expected err=0 busy=1", O_ERR, O_BUSY);
    end
    wait_end(200, gd, ge, t);
    n_assert++;
    if (!gd || ge) begin
      n_fail++; $display("FAIL rerun_after_nack: got done=%0d err=%0d, expected 1 0", gd, ge);
    end
  endtask

  task automatic test_wrap;
    bit gd, ge; int t;
    clear_rom(8'hD0);
    for (int i = 0; i < 16; i++) push_txn(1'b1, 8'hD0, 8'h00, 5'd1, 8'hD0);
    pulse_start();
    wait_end(1000, gd, ge, t);
    n_assert++;
    if (!ge || gd || exp_q.size() != 0 || O_ADDR_ROM !== 4'd15) begin
      n_fail++; $display("FAIL pc_wrap: got err=%0d done=%0d left=%0d pc=%0d, expected err=1 done=0 left=0 pc=15",
                         ge, gd, exp_q.size(), O_ADDR_ROM);
    end
  endtask

  task automatic test_rst_mid;
    bit gd, ge; int t;
    clear_rom(8'h00);
    rom_mem[0] = 8'h2E;
    push_txn(1'b0, 8'hF4, 8'h2E, 5'd1, 8'h2E);
    pulse_start();
    for (int i = 0; i < 200 && dones.size() == 0; i++) @(negedge CLK);
    repeat (100) @(negedge CLK);
    n_assert++;
    if (dones.size() != 1 || O_BUSY !== 1'b1) begin
      n_fail++; $display("FAIL reach_wait: got dones=%0d busy=%0d, expected 1 1", dones.size(), O_BUSY);
    end
    RST = 1'b1;
    #1;
    n_assert++;
    if (outs !== '0) begin
      n_fail++; $display("FAIL rst_in_wait: got %h, expected 0", outs);
    end
    exp_q.delete();
    @(negedge CLK) RST = 1'b0;
    rom_mem[0] = 8'hD0;
    push_txn(1'b1, 8'hD0, 8'h00, 5'd1, 8'hD0);
    pulse_start();
    wait_end(200, gd, ge, t);
    n_assert++;
    if (!gd || exp_q.size() != 0) begin
      n_fail++; $display("FAIL rerun_after_wait_rst: got done=%0d left=%0d, expected 1 0", gd, exp_q.size());
    end

    clear_rom(8'h00);
    rom_mem[0] = 8'hAA;
    push_txn(1'b1, 8'hAA, 8'h00, 5'd22, 8'hAA);
    pulse_start();
    for (int i = 0; i < 100 && !i2c_busy; i++) @(negedge CLK);
    RST = 1'b1;
    #1;
    n_assert++;
    if (outs !== '0 || starts.size() != 1) begin
      n_fail++; $display("FAIL rst_in_xfer: got outs=%h starts=%0d, expected 0 1", outs, starts.size());
    end
    exp_q.delete();
    @(negedge CLK) RST = 1'b0;
    push_txn(1'b1, 8'hAA, 8'h00, 5'd22, 8'hAA);
    pulse_start();
    wait_end(200, gd, ge, t);
    n_assert++;
    if (!gd || ge || exp_q.size() != 0) begin
      n_fail++; $display("FAIL rerun_after_xfer_rst: got done=%0d err=%0d left=%0d, expected 1 0 0",
                         gd, ge, exp_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom_mem[i] = 8'h00;
    test_reset();
    test_single_read();
    test_sequence();
    test_long_conv();
    test_soft_reset();
    test_bad_opcode();
    test_nack();
    test_wrap();
    test_rst_mid();
    repeat (5) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
